relu_sched: RTL and testbench
=============================

Name: relu_sched

Overview:
- Shares one combinational ReLU datapath (24-bit signed in/out, enable-gated) between NUM_CH convolution channel streams.
- Round-robin arbitration; each channel retires after one full feature map of PIX_PER_MAP results.
- One registered output stage with valid/ready backpressure.
- Sits between the per-channel conv accumulators and the pooling/storage stage; the top-level layer sequencer starts it once per layer.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- DW, 24, data width; must match the ReLU datapath.
- PIX_PER_MAP, 676, results per channel per layer (26x26).
- CW, 10, pixel counter width; must satisfy 2^CW > PIX_PER_MAP.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, single-cycle pulse; begins a layer; honoured only in IDLE.
- relu_en_cfg, input, 1, ReLU enable for the layer; sampled on an accepted start.
- busy, output, 1, high in RUN and DRAIN.
- done, output, 1, single-cycle pulse when the layer completes.
- req_valid, input, NUM_CH, per-channel data valid.
- req_data, input, NUM_CH*DW, channel k occupies bits [k*DW +: DW].
- req_ready, output, NUM_CH, per-channel accept; one-hot or zero.
- relu_en, output, 1, registered enable driven to the ReLU datapath.
- relu_din, output, DW, granted channel data driven to the ReLU datapath.
- relu_dout, input, DW, ReLU result.
- out_valid, output, 1, output register holds data.
- out_ready, input, 1, downstream accept.
- out_data, output, DW, ReLU result.
- out_ch, output, 3, source channel index.
- out_last, output, 1, final result of that channel's map.

Behaviour:
- Reset values:
  - State = IDLE.
  - busy, done, out_valid, out_last, req_ready, relu_en = 0.
  - out_data, out_ch = 0; relu_din = 0.
  - All pixel counters = 0; retired mask = 0; rr pointer = 0.
- Reset mid-operation aborts the layer immediately. No done is issued. Data in flight is discarded.
- FSM transitions:
  - IDLE -> RUN on start. Clears counters and retired mask, sets rr pointer = 0, latches relu_en <= relu_en_cfg.
  - RUN -> DRAIN when the last channel retires on an accepted transfer.
  - DRAIN -> DONE when out_valid=0 or (out_valid & out_ready).
  - DONE -> IDLE unconditionally; done=1 only in DONE (1 cycle).
  - start outside IDLE is ignored.
- Arbitration (RUN only, combinational):
  - Eligible[k] = req_valid[k] & ~retired[k].
  - Grant goes to the first eligible channel searching from rr pointer upward with wrap.
  - Grant is issued only when the output register can load: out_valid=0 or out_ready=1.
  - req_ready = one-hot of the grant, else 0.
  - A transfer occurs when req_valid[g] & req_ready[g].
  - After a transfer, rr pointer <= g+1 (mod NUM_CH).
- Datapath:
  - relu_din = req_data slice of the granted channel; 0 when there is no grant.
  - On a transfer, next edge: out_data <= relu_dout, out_ch <= g, out_valid <= 1, out_last <= (cnt[g] == PIX_PER_MAP-1).
  - Latency: 1 cycle from input handshake to out_valid.
  - Throughput: 1 result per cycle when out_ready is held high.
  - out_valid & ~out_ready: out_data, out_ch, out_last are held stable and no grant is issued.
  - Output consumed with no new transfer: out_valid <= 0.
  - Simultaneous consume and load: register reloads, out_valid stays 1.
- Counters:
  - cnt[g] increments on each transfer.
  - At PIX_PER_MAP-1 the transfer sets retired[g] and cnt[g] wraps to 0.
  - A retired channel gets no further grants.
  - Its req_valid is ignored for the rest of the layer.
- relu_en is constant for the whole layer and changes only on an accepted start.

Test Plan:
- Reset, then start with relu_en_cfg=1, NUM_CH=4, PIX_PER_MAP=4, all req_valid=1, out_ready=1:
  - Outputs arrive in channel order 0,1,2,3,0,1,... for 16 beats.
  - out_last on beats 13-16.
  - done pulses exactly once, 2 cycles after the final beat is accepted.
- Data sign check with relu_en=1:
  - Input 0x800001 -> out_data=0x000000.
  - Input 0x7FFFFF -> 0x7FFFFF.
  - Input 0x000000 -> 0x000000.
- Data sign check with relu_en=0:
  - All out_data = 0.
  - Full handshake and count sequence unchanged.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream.
  - out_data and out_ch stable throughout.
  - req_ready = 0.
  - No beat lost or duplicated.
  - Counters end at retired=4'b1111.
- Sparse requesters: only channel 2 valid for its 4 beats, then channels 0, 1, 3.
  - Channel 2 retires first.
  - Later req_valid[2]=1 is never granted.
  - Total beats = 16.
- Asynchronous rst pulse after 6 beats:
  - All outputs zero immediately.
  - No done.
  - A following start runs a complete 16-beat layer.

Source files
------------

// File: rtl/relu_sched.sv
`default_nettype none
// ============================================================================
//  Module      : relu_sched
//  Description : Round-robin scheduler that shares one combinational ReLU
//                datapath between NUM_CH convolution channel streams. Each
//                channel retires after PIX_PER_MAP results. A single
//                registered output stage provides valid/ready backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module relu_sched #(
    parameter int NUM_CH      = 4,
    parameter int DW          = 24,
    parameter int PIX_PER_MAP = 676,
    parameter int CW          = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 relu_en_cfg,
    output logic                 busy,
    output logic                 done,
    input  logic [NUM_CH-1:0]    req_valid,
    input  logic [NUM_CH*DW-1:0] req_data,
    output logic [NUM_CH-1:0]    req_ready,
    output logic                 relu_en,
    output logic [DW-1:0]        relu_din,
    input  logic [DW-1:0]        relu_dout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [2:0]           out_ch,
    output logic                 out_last
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CW-1:0] LAST_CNT = CW'(PIX_PER_MAP - 1);

    logic [1:0]        state_q, state_d;
    logic [2:0]        rr_q;
    logic              relu_en_q;
    logic              out_valid_q;
    logic [DW-1:0]     out_data_q;
    logic [2:0]        out_ch_q;
    logic              out_last_q;

    logic [NUM_CH-1:0] w_retired;
    logic [NUM_CH-1:0] w_is_last;
    logic [NUM_CH-1:0] w_elig;
    logic [NUM_CH-1:0] w_rot;
    logic              w_can_grant;
    logic              w_grant_vld;
    logic [2:0]        w_grant_ch;
    logic [3:0]        w_sum;
    logic              w_start_acc;
    logic              w_last_hit;
    logic              w_all_ret_next;

    assign w_start_acc = (state_q == S_IDLE) && start;
    assign w_can_grant = (state_q == S_RUN) && (!out_valid_q || out_ready);
    assign w_elig      = req_valid & ~w_retired;
    // Rotate eligibility so bit 0 is the channel at the round-robin pointer.
    assign w_rot       = NUM_CH'({w_elig, w_elig} >> rr_q);

    // Find the first eligible channel at or after the pointer, with wrap.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_ch  = '0;
        w_sum       = '0;
        if (w_can_grant) begin
            // Descending scan so the lowest rotated offset wins.
            for (int j = NUM_CH - 1; j >= 0; j--) begin
                if (w_rot[j]) begin
                    w_grant_vld = 1'b1;
                    w_sum       = {1'b0, rr_q} + 4'(j);
                end
            end
            if (w_sum >= 4'(NUM_CH)) begin
                w_sum = w_sum - 4'(NUM_CH);
            end
            w_grant_ch = w_sum[2:0];
        end
    end

    // One-hot ready and data mux for the granted channel.
    always_comb begin
        req_ready = '0;
        relu_din  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_grant_vld && (w_grant_ch == 3'(k))) begin
                req_ready[k] = 1'b1;
                relu_din     = req_data[k*DW +: DW];
            end
        end
    end

    // Because req_ready is one-hot on a grant, these reduce to the granted channel.
    assign w_last_hit     = |(w_is_last & req_ready);
    assign w_all_ret_next = &(w_retired | (w_is_last & req_ready));

    // Per-channel pixel counter and retire flag.
    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            logic [CW-1:0] cnt_q;
            logic          retired_q;

            assign w_is_last[k] = (cnt_q == LAST_CNT);
            assign w_retired[k] = retired_q;

            // Count transfers; the final pixel wraps the counter and retires the channel.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q     <= '0;
                    retired_q <= 1'b0;
                end else if (w_start_acc) begin
                    cnt_q     <= '0;
                    retired_q <= 1'b0;
                end else if (req_ready[k]) begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q     <= '0;
                        retired_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (w_grant_vld && w_all_ret_next) state_d = S_DRAIN;
            S_DRAIN: if (!out_valid_q || out_ready) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_RUN:   busy = 1'b1;
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Round-robin pointer and layer-wide ReLU enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q      <= '0;
            relu_en_q <= 1'b0;
        end else if (w_start_acc) begin
            rr_q      <= '0;
            relu_en_q <= relu_en_cfg;
        end else if (w_grant_vld) begin
            rr_q <= (w_grant_ch == 3'(NUM_CH - 1)) ? 3'd0 : w_grant_ch + 3'd1;
        end
    end

    // Output register: load on transfer, clear when consumed without reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
        end else if (w_grant_vld) begin
            out_valid_q <= 1'b1;
            out_data_q  <= relu_dout;
            out_ch_q    <= w_grant_ch;
            out_last_q  <= w_last_hit;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign relu_en   = relu_en_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_relu_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_relu_sched
//  Description : Self-checking bench for relu_sched with a cycle-level
//                reference model and directed layer scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_relu_sched;

    localparam int N  = 4;
    localparam int DW = 24;
    localparam int P  = 4;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            relu_en_cfg = 1'b0;
    logic            busy, done;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            relu_en;
    logic [DW-1:0]   relu_din, relu_dout;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [DW-1:0]   out_data;
    logic [2:0]      out_ch;
    logic            out_last;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    relu_sched #(.NUM_CH(N), .DW(DW), .PIX_PER_MAP(P), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .relu_en_cfg(relu_en_cfg),
        .busy(busy), .done(done), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .relu_en(relu_en), .relu_din(relu_din),
        .relu_dout(relu_dout), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ch(out_ch), .out_last(out_last)
    );

    // ReLU function: negative or disabled gives zero.
    function automatic logic [DW-1:0] relu(input logic [DW-1:0] x, input logic en);
        if (!en || x[DW-1]) return '0;
        return x;
    endfunction

    // Stand-in for the shared ReLU datapath.
    assign relu_dout = relu(relu_din, relu_en);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // ---------------- reference model state ----------------
    bit            m_active, m_flush, m_done, m_ov, m_olast, m_en;
    logic [DW-1:0] m_od;
    int            m_och, m_rr;
    int            m_cnt [N];
    logic [N-1:0]  m_ret;
    int            cyc = 0, done_cnt = 0, done_cyc = 0, last_xfer_cyc = 0;
    int            log_ch [$];
    logic [DW-1:0] log_data [$];
    bit            log_last [$];

    task automatic model_reset();
        m_active = 0; m_flush = 0; m_done = 0; m_ov = 0; m_olast = 0; m_en = 0;
        m_od = '0; m_och = 0; m_rr = 0; m_ret = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    // Per-cycle compare against the model, then advance the model one cycle.
    initial begin : p_cmp
        int            g, k;
        logic [N-1:0]  eready;
        logic [DW-1:0] edin;
        bit            old_ov, old_flush, was_idle;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                model_reset();
                chk("rst_out_valid", out_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_req_ready", req_ready, 0);
                chk("rst_relu_en", relu_en, 0);
            end else begin
                chk("out_valid", out_valid, m_ov);
                if (m_ov) begin
                    chk("out_data", out_data, m_od);
                    chk("out_ch", out_ch, m_och);
                    chk("out_last", out_last, m_olast);
                end
                chk("busy", busy, m_active || m_flush);
                chk("done", done, m_done);
                chk("relu_en", relu_en, m_en);
                g = -1;
                if (m_active && (!m_ov || out_ready)) begin
                    for (int i = 0; i < N; i++) begin
                        k = (m_rr + i) % N;
                        if (g < 0 && ((req_valid >> k) & 1) != 0 && ((m_ret >> k) & 1) == 0) g = k;
                    end
                end
                eready = (g >= 0) ? (N'(1) << g) : '0;
                edin   = (g >= 0) ? DW'(req_data >> (g * DW)) : '0;
                chk("req_ready", req_ready, eready);
                chk("relu_din", relu_din, edin);
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (out_valid && out_ready) begin
                    log_ch.push_back(int'(out_ch));
                    log_data.push_back(out_data);
                    log_last.push_back(out_last);
                end
                old_ov    = m_ov;
                old_flush = m_flush;
                was_idle  = !m_active && !m_flush && !m_done;
                m_done    = 0;
                if (old_flush && (!old_ov || out_ready)) begin
                    m_flush = 0;
                    m_done  = 1;
                end
                if (g >= 0) begin
                    m_ov    = 1;
                    m_od    = relu(edin, m_en);
                    m_och   = g;
                    m_olast = (m_cnt[g] == P - 1);
                    if (m_cnt[g] == P - 1) begin
                        m_cnt[g] = 0;
                        m_ret    = m_ret | (N'(1) << g);
                    end else begin
                        m_cnt[g]++;
                    end
                    m_rr = (g + 1) % N;
                    last_xfer_cyc = cyc;
                    if (&m_ret) begin
                        m_active = 0;
                        m_flush  = 1;
                    end
                end else if (out_ready) begin
                    m_ov = 0;
                end
                if (was_idle && start) begin
                    m_active = 1;
                    m_en     = relu_en_cfg;
                    m_rr     = 0;
                    m_ret    = '0;
                    for (int i = 0; i < N; i++) m_cnt[i] = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_data(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                            input logic [DW-1:0] d2, input logic [DW-1:0] d3);
        req_data = {d3, d2, d1, d0};
    endtask

    task automatic start_layer(input bit en, output int d0);
        log_ch.delete();
        log_data.delete();
        log_last.delete();
        d0 = done_cnt;
        @(posedge clk); #1;
        relu_en_cfg = en;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int t;
        t = 0;
        while (log_ch.size() < n && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("reach_beats", (log_ch.size() >= n) ? 1 : 0, 1);
    endtask

    task automatic finish_layer(input int d0);
        int t;
        t = 0;
        while (done_cnt == d0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("done_once", done_cnt - d0, 1);
        chk("done_latency", done_cyc - last_xfer_cyc, 2);
        chk("idle_after_done", busy, 0);
    endtask

    task automatic check_stream();
        int nb [N];
        int nl [N];
        chk("total_beats", log_ch.size(), 16);
        for (int c = 0; c < N; c++) begin
            nb[c] = 0;
            nl[c] = 0;
        end
        for (int i = 0; i < log_ch.size(); i++) begin
            if (log_ch[i] < N) begin
                nb[log_ch[i]]++;
                if (log_last[i]) begin
                    nl[log_ch[i]]++;
                    chk("last_on_4th", nb[log_ch[i]], 4);
                end
            end
        end
        for (int c = 0; c < N; c++) begin
            chk("ch_beats", nb[c], 4);
            chk("ch_lasts", nl[c], 1);
        end
    endtask

    task automatic check_rr_order(input bit en);
        for (int i = 0; i < 16 && i < log_ch.size(); i++) begin
            chk("rr_order", log_ch[i], i % 4);
            chk("last_beats_13_16", log_last[i], (i >= 12) ? 1 : 0);
            if (!en) chk("disabled_zero", log_data[i], 0);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin : p_main
        int d0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_busy", busy, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_relu_din", relu_din, 0);

        // Layer A: enabled ReLU, all channels streaming.
        set_data(24'h800001, 24'h7FFFFF, 24'h000000, 24'h123456);
        req_valid = 4'hF;
        start_layer(1'b1, d0);
        finish_layer(d0);
        check_stream();
        check_rr_order(1'b1);
        if (log_data.size() >= 4) begin
            chk("sign_neg", log_data[0], 24'h000000);
            chk("sign_max", log_data[1], 24'h7FFFFF);
            chk("sign_zero", log_data[2], 24'h000000);
            chk("sign_pos", log_data[3], 24'h123456);
        end

        // Layer B: ReLU disabled, same handshake sequence, all-zero data.
        start_layer(1'b0, d0);
        finish_layer(d0);
        check_stream();
        check_rr_order(1'b0);

        // Layer C: 5 cycles of downstream backpressure mid-stream.
        set_data(24'h000011, 24'h000022, 24'h000033, 24'h000044);
        start_layer(1'b1, d0);
        wait_beats(6);
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        finish_layer(d0);
        check_stream();

        // Layer D: only channel 2 requests first, then everyone.
        set_data(24'h000010, 24'h000020, 24'h000100, 24'h000040);
        req_valid = 4'b0100;
        start_layer(1'b1, d0);
        wait_beats(4);
        repeat (3) @(posedge clk);
        #1;
        chk("sparse_stall", log_ch.size(), 4);
        req_valid = 4'hF;
        finish_layer(d0);
        check_stream();
        for (int i = 0; i < 4 && i < log_ch.size(); i++) begin
            chk("sparse_ch2_first", log_ch[i], 2);
            chk("sparse_ch2_data", log_data[i], 24'h000100);
        end

        // Layer E: asynchronous reset after 6 beats aborts the layer.
        set_data(24'h000001, 24'h000002, 24'h000003, 24'h000004);
        start_layer(1'b1, d0);
        wait_beats(6);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_data", out_data, 0);
        chk("abort_out_ch", out_ch, 0);
        chk("abort_out_last", out_last, 0);
        chk("abort_busy", busy, 0);
        chk("abort_req_ready", req_ready, 0);
        chk("abort_relu_en", relu_en, 0);
        chk("abort_relu_din", relu_din, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);
        start_layer(1'b1, d0);
        finish_layer(d0);
        check_stream();
        check_rr_order(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : p_watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule
`default_nettype wire
